// File: rtl/mem_port_arbiter.sv
// Refill-port arbiter: shares one word-wide memory port between the
// instruction cache (port 0) and the data cache (port 1). Miss pulses are
// captured as pending requests and served as whole bursts, round-robin.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no burst active; grant a pending port if any
// S_ISSUE | one-cycle memory request with the captured miss address
// S_BURST | forward memory acks/data to the owner until last word or timeout
module mem_port_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int ADR_WIDTH  = 32,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_ic2arb,
    input  logic [ADR_WIDTH-1:0]  adr_ic2arb,
    output logic                  ack_arb2ic,
    output logic [WORD_WIDTH-1:0] dat_arb2ic,
    input  logic                  req_dc2arb,
    input  logic [ADR_WIDTH-1:0]  adr_dc2arb,
    output logic                  ack_arb2dc,
    output logic [WORD_WIDTH-1:0] dat_arb2dc,
    output logic                  req_arb2mem,
    output logic [ADR_WIDTH-1:0]  adr_arb2mem,
    input  logic                  ack_mem2arb,
    input  logic [WORD_WIDTH-1:0] dat_mem2arb,
    output logic                  owner,
    output logic                  busy,
    output logic                  err_drop,
    output logic                  err_timeout
);
    localparam int WC_W = $clog2(BURST_LEN);
    localparam logic [WC_W-1:0]     WCNT_LAST = WC_W'(BURST_LEN - 1);
    localparam logic [TO_WIDTH-1:0] TO_LOAD   = TO_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [1:0]             pending, req_v, take, lost, rel;
    logic [ADR_WIDTH-1:0]   padr [2];
    logic                   last, winner, end_burst, abort, stray;
    logic [WC_W-1:0]        wcnt;
    logic [TO_WIDTH-1:0]    to_left;   // idle cycles left before abort

    assign req_v = {req_dc2arb, req_ic2arb};

    // Next-state decode: grant in IDLE, end a burst on last ack or timeout
    always_comb begin
        state_nxt = state;
        winner    = (pending == 2'b11) ? ~last : pending[1];
        end_burst = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pending) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                state_nxt = S_BURST;
            end
            S_BURST: begin
                if (ack_mem2arb) begin
                    if (wcnt == WCNT_LAST) begin
                        end_burst = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else if (to_left == '0) begin
                    abort     = 1'b1;
                    end_burst = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture: a pulse coinciding with its own port's release re-arms it
    always_comb begin
        rel   = end_burst ? {owner, ~owner} : 2'b00;
        take  = req_v & (~pending | rel);
        lost  = req_v & pending & ~rel;
        stray = ack_mem2arb && (state != S_BURST);
    end

    // Memory-side request and zero-latency routing of acks/data to the owner
    always_comb begin
        req_arb2mem = (state == S_ISSUE);
        busy        = (state != S_IDLE);
        adr_arb2mem = '0;
        ack_arb2ic  = 1'b0;
        ack_arb2dc  = 1'b0;
        dat_arb2ic  = '0;
        dat_arb2dc  = '0;
        case (state)
            S_ISSUE: adr_arb2mem = padr[owner];
            S_BURST: begin
                adr_arb2mem = owner ? adr_dc2arb : adr_ic2arb;
                if (owner) begin
                    ack_arb2dc = ack_mem2arb;
                    dat_arb2dc = dat_mem2arb;
                end else begin
                    ack_arb2ic = ack_mem2arb;
                    dat_arb2ic = dat_mem2arb;
                end
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Pending flags, captured miss addresses and the sticky drop error
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 2'b00;
            padr[0]  <= '0;
            padr[1]  <= '0;
            err_drop <= 1'b0;
        end else begin
            pending <= (pending & ~rel) | take;
            if (take[0]) padr[0] <= adr_ic2arb;
            if (take[1]) padr[1] <= adr_dc2arb;
            if ((|lost) || stray) err_drop <= 1'b1;
        end
    end

    // Grant owner, round-robin history, word count and timeout down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= 1'b0;
            last        <= 1'b1;
            wcnt        <= '0;
            to_left     <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= abort;
            if (state == S_IDLE && (|pending)) owner <= winner;
            if (state == S_ISSUE) begin
                wcnt    <= '0;
                to_left <= TO_LOAD;
            end
            if (state == S_BURST) begin
                if (ack_mem2arb) begin
                    wcnt    <= wcnt + WC_W'(1);
                    to_left <= TO_LOAD;
                end else if (to_left != '0) begin
                    to_left <= to_left - TO_WIDTH'(1);
                end
            end
            if (end_burst) last <= owner;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a behavioural model.
module tb_mem_port_arbiter;
    localparam int WW = 32;
    localparam int AW = 32;
    localparam int BL = 4;
    localparam int TO = 20;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_ic2arb = 1'b0, req_dc2arb = 1'b0, ack_mem2arb = 1'b0;
    logic [AW-1:0] adr_ic2arb = '0, adr_dc2arb = '0;
    logic [WW-1:0] dat_mem2arb = '0;
    logic          ack_arb2ic, ack_arb2dc, req_arb2mem, owner, busy, err_drop, err_timeout;
    logic [WW-1:0] dat_arb2ic, dat_arb2dc;
    logic [AW-1:0] adr_arb2mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_WIDTH(WW), .ADR_WIDTH(AW), .BURST_LEN(BL),
                       .TIMEOUT(TO), .TO_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .req_ic2arb(req_ic2arb), .adr_ic2arb(adr_ic2arb),
        .ack_arb2ic(ack_arb2ic), .dat_arb2ic(dat_arb2ic),
        .req_dc2arb(req_dc2arb), .adr_dc2arb(adr_dc2arb),
        .ack_arb2dc(ack_arb2dc), .dat_arb2dc(dat_arb2dc),
        .req_arb2mem(req_arb2mem), .adr_arb2mem(adr_arb2mem),
        .ack_mem2arb(ack_mem2arb), .dat_mem2arb(dat_mem2arb),
        .owner(owner), .busy(busy), .err_drop(err_drop), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // behavioural model: which port holds the memory, whether its request
    // has gone out, how many words arrived and how long memory has been quiet
    int            m_act;
    bit            m_issued;
    int            m_words, m_quiet;
    bit [1:0]      m_pend;
    logic [AW-1:0] m_padr [2];
    bit            m_last, m_owner, m_edrop, m_eto;

    bit  checks_on = 0;
    int  auto_ack_pct = 0, stray_pct = 0, req_pct = 0, rst_pct = 0;
    int  cyc_no = 0, n_ack_ic = 0, n_ack_dc = 0;
    bit  gq[$];
    int  gi[$];

    function automatic void model_reset();
        m_act = -1; m_issued = 0; m_words = 0; m_quiet = 0; m_pend = 2'b00;
        m_padr[0] = '0; m_padr[1] = '0;
        m_last = 1; m_owner = 0; m_edrop = 0; m_eto = 0;
    endfunction

    task automatic model_check();
        bit in_burst, in_issue;
        logic [AW-1:0] ea;
        logic [63:0] e_ic, e_dc;
        in_burst = (m_act >= 0) && m_issued;
        in_issue = (m_act >= 0) && !m_issued;
        ea = '0;
        if (in_issue) ea = m_padr[m_act];
        else if (in_burst) ea = (m_act == 1) ? adr_dc2arb : adr_ic2arb;
        e_ic = (in_burst && m_act == 0) ? {31'b0, ack_mem2arb, dat_mem2arb} : 64'b0;
        e_dc = (in_burst && m_act == 1) ? {31'b0, ack_mem2arb, dat_mem2arb} : 64'b0;
        check("mem_side", {31'b0, req_arb2mem, adr_arb2mem}, {31'b0, in_issue, ea});
        check("ic_side", {31'b0, ack_arb2ic, dat_arb2ic}, e_ic);
        check("dc_side", {31'b0, ack_arb2dc, dat_arb2dc}, e_dc);
        check("status", {60'b0, busy, owner, err_drop, err_timeout},
              {60'b0, (m_act >= 0), m_owner, m_edrop, m_eto});
    endtask

    function automatic void model_step();
        bit ended, to_hit, in_burst;
        int prev;
        bit [1:0] rq;
        logic [AW-1:0] ra [2];
        if (rst) begin
            model_reset();
            return;
        end
        ended = 0; to_hit = 0; prev = m_act;
        in_burst = (m_act >= 0) && m_issued;
        rq = {req_dc2arb, req_ic2arb};
        ra[0] = adr_ic2arb; ra[1] = adr_dc2arb;
        if (ack_mem2arb && !in_burst) m_edrop = 1;
        if (in_burst) begin
            if (ack_mem2arb) begin
                m_words++; m_quiet = 0;
                if (m_words == BL) ended = 1;
            end else begin
                m_quiet++;
                if (m_quiet == TO) begin ended = 1; to_hit = 1; end
            end
        end else if (m_act >= 0) begin
            m_issued = 1; m_words = 0; m_quiet = 0;
        end else if (m_pend != 2'b00) begin
            if (m_pend[0] && !m_pend[1])      m_act = 0;
            else if (!m_pend[0])              m_act = 1;
            else                              m_act = (m_last == 0) ? 1 : 0;
            m_issued = 0;
            m_owner  = (m_act == 1);
        end
        if (ended) begin
            m_last = (prev == 1);
            m_pend[prev] = 0;
            m_act = -1;
        end
        for (int p = 0; p < 2; p++) begin
            if (rq[p]) begin
                if (!m_pend[p]) begin m_pend[p] = 1; m_padr[p] = ra[p]; end
                else m_edrop = 1;
            end
        end
        m_eto = to_hit;
    endfunction

    task automatic cyc();
        bit mb;
        mb = (m_act >= 0) && m_issued;
        if (mb && auto_ack_pct > 0 && $urandom_range(0, 99) < auto_ack_pct) ack_mem2arb = 1;
        if (!mb && stray_pct > 0 && $urandom_range(0, 99) < stray_pct) ack_mem2arb = 1;
        if (req_pct > 0 && $urandom_range(0, 99) < req_pct) begin req_ic2arb = 1; adr_ic2arb = $urandom; end
        if (req_pct > 0 && $urandom_range(0, 99) < req_pct) begin req_dc2arb = 1; adr_dc2arb = $urandom; end
        if (rst_pct > 0 && $urandom_range(0, 999) < rst_pct) rst = 1;
        @(negedge clk);
        if (checks_on) model_check();
        if (req_arb2mem) begin gq.push_back(owner); gi.push_back(cyc_no); end
        if (ack_arb2ic) n_ack_ic++;
        if (ack_arb2dc) n_ack_dc++;
        model_step();
        cyc_no++;
        @(posedge clk);
        #1;
        req_ic2arb = 0; req_dc2arb = 0; ack_mem2arb = 0; rst = 0;
        adr_ic2arb = $urandom; adr_dc2arb = $urandom; dat_mem2arb = $urandom;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
        gq.delete(); gi.delete();
    endtask

    int a0, d0, n;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {57'b0, req_arb2mem, busy, owner, err_drop, err_timeout,
                           ack_arb2ic, ack_arb2dc}, 64'b0);
        check("rst_adr", {32'b0, adr_arb2mem}, 64'b0);
        check("rst_dat", {dat_arb2ic, dat_arb2dc}, 64'b0);
        rst = 0;
        checks_on = 1;

        // T1: lone ic miss
        req_ic2arb = 1; adr_ic2arb = 32'h0000_1234; cyc();
        cyc();
        check("t1_req_at_2", {63'b0, req_arb2mem}, 64'd1);
        check("t1_adr", {32'b0, adr_arb2mem}, 64'h1234);
        auto_ack_pct = 100; a0 = n_ack_ic; d0 = n_ack_dc;
        repeat (5) cyc();
        check("t1_ic_acks", n_ack_ic - a0, 4);
        check("t1_dc_acks", n_ack_dc - d0, 0);
        check("t1_busy_after", {63'b0, busy}, 64'd0);

        // T2: simultaneous misses after reset
        do_reset();
        req_ic2arb = 1; req_dc2arb = 1; cyc();
        repeat (14) cyc();
        check("t2_grants", gq.size(), 2);
        if (gq.size() >= 2) begin
            check("t2_first", {63'b0, gq[0]}, 64'd0);
            check("t2_second", {63'b0, gq[1]}, 64'd1);
            check("t2_gap", gi[1] - gi[0], 6);
        end

        // T3: both ports continuously requesting
        do_reset();
        n = 0;
        while (gq.size() < 6 && n < 200) begin
            req_ic2arb = 1; req_dc2arb = 1; cyc(); n++;
        end
        check("t3_grants", {63'b0, gq.size() >= 6}, 64'd1);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            check("t3_order", {63'b0, gq[i]}, i % 2);

        // T4: dc burst stalls after two words
        do_reset();
        auto_ack_pct = 0; d0 = n_ack_dc;
        req_dc2arb = 1; cyc();
        cyc(); cyc();
        ack_mem2arb = 1; cyc();
        ack_mem2arb = 1; cyc();
        n = 0;
        while (!err_timeout && n < TO + 5) begin cyc(); n++; end
        check("t4_to_delay", n, TO);
        check("t4_busy", {63'b0, busy}, 64'd0);
        repeat (5) cyc();
        check("t4_dc_acks", n_ack_dc - d0, 2);
        check("t4_to_pulse", {63'b0, err_timeout}, 64'd0);

        // T5: repeated ic pulses while pending plus a stray ack
        do_reset();
        auto_ack_pct = 100; a0 = n_ack_ic;
        req_ic2arb = 1; adr_ic2arb = 32'hA000_0040; cyc();
        req_ic2arb = 1; adr_ic2arb = 32'hB000_0080; ack_mem2arb = 1; cyc();
        check("t5_drop", {63'b0, err_drop}, 64'd1);
        check("t5_adr_kept", {32'b0, adr_arb2mem}, 64'hA000_0040);
        req_ic2arb = 1; adr_ic2arb = 32'hC000_00C0; cyc();
        repeat (8) cyc();
        check("t5_bursts", gq.size(), 1);
        check("t5_ic_acks", n_ack_ic - a0, 4);
        check("t5_drop_sticky", {63'b0, err_drop}, 64'd1);

        // T6: reset during the second word of an ic burst
        do_reset();
        auto_ack_pct = 0;
        req_ic2arb = 1; cyc();
        cyc(); cyc();
        ack_mem2arb = 1; cyc();
        rst = 1; ack_mem2arb = 1; cyc();
        check("t6_ctrl", {57'b0, req_arb2mem, busy, owner, err_drop, err_timeout,
                          ack_arb2ic, ack_arb2dc}, 64'b0);
        check("t6_adr", {32'b0, adr_arb2mem}, 64'b0);
        a0 = n_ack_ic;
        repeat (3) begin ack_mem2arb = 1; cyc(); end
        check("t6_no_fwd", n_ack_ic - a0, 0);
        check("t6_stray", {63'b0, err_drop}, 64'd1);
        check("t6_idle", {63'b0, busy}, 64'd0);

        // randomized traffic
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            auto_ack_pct = $urandom_range(5, 100);
            stray_pct    = (ep % 2) ? 2 : 0;
            req_pct      = $urandom_range(5, 60);
            rst_pct      = (ep == 5) ? 4 : 0;
            repeat (400) cyc();
        end
        auto_ack_pct = 0; stray_pct = 0; req_pct = 0; rst_pct = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
